// File: rtl/and_sched_pkg.sv
// and_sched_pkg: shared state type and width/count helpers for the and_sched scheduler.
package and_sched_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    function automatic int n_width(input int dwidth);
        return $clog2(dwidth + 1);
    endfunction

    function automatic int id_width(input int nreq);
        return nreq > 1 ? $clog2(nreq) : 1;
    endfunction

    // An empty reduction still spends one EVAL cycle.
    function automatic int chunk_count(input int n, input int chunk);
        return n == 0 ? 1 : (n + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/and_sched_rr_pick.sv
// and_sched_rr_pick: combinational round-robin picker, first request at or after ptr (wrapping).
module and_sched_rr_pick import and_sched_pkg::*; #(
    parameter int NREQ = 4,
    localparam int IW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] j;

    always_comb begin
        j = '0;
        idx = '0;
        any = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) idx = j;
        end
        grant = any ? NREQ'(1) << idx : '0;
    end

endmodule

// File: rtl/and_sched.sv
// and_sched: round-robin scheduler sharing one chunked AND-reduction unit among NREQ requesters.
// Define AND_SCHED_EARLY_EXIT_EN to finish as soon as a chunk reduces to 0.
module and_sched import and_sched_pkg::*; #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 128,
    parameter int CHUNK  = 32,
    localparam int NW = n_width(DWIDTH),
    localparam int IW = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    input  logic [NREQ*NW-1:0]     req_n,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IW-1:0]          resp_id,
    output logic                   resp_value,
    output logic                   busy
);

    localparam int NCH = DWIDTH / CHUNK;
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;

    state_t            state;
    logic [IW-1:0]     rr_ptr, id, g_idx;
    logic [NREQ-1:0]   grant;
    logic              any, acc, c_and, last, done;
    logic [CW-1:0]     chunk;
    logic [DWIDTH-1:0] data;
    logic [NW-1:0]     n, n_raw, n_clamp;
    logic [CHUNK-1:0]  d_chunk, m_chunk;

    and_sched_rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(grant),
        .idx  (g_idx),
        .any  (any)
    );

    assign req_ready  = state == IDLE ? grant : '0;
    assign resp_valid = state == RESP;
    assign resp_value = resp_valid & acc;
    assign resp_id    = id;
    assign busy       = state != IDLE;

    always_comb begin
        n_raw = req_n[int'(g_idx)*NW +: NW];
        n_clamp = n_raw > NW'(DWIDTH) ? NW'(DWIDTH) : n_raw;
        d_chunk = data[int'(chunk)*CHUNK +: CHUNK];
        m_chunk = '0;
        for (int b = 0; b < CHUNK; b++) m_chunk[b] = int'(chunk) * CHUNK + b < int'(n);
        c_and = &(d_chunk | ~m_chunk);
        last = int'(chunk) == chunk_count(int'(n), CHUNK) - 1;
`ifdef AND_SCHED_EARLY_EXIT_EN
        done = last | ~c_and;
`else
        done = last;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            acc    <= 1'b1;
            chunk  <= '0;
            id     <= '0;
            data   <= '0;
            n      <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    data   <= req_data[int'(g_idx)*DWIDTH +: DWIDTH];
                    n      <= n_clamp;
                    id     <= g_idx;
                    acc    <= 1'b1;
                    chunk  <= '0;
                    rr_ptr <= g_idx == IW'(NREQ - 1) ? '0 : g_idx + 1'b1;
                    state  <= EVAL;
                end
                EVAL: begin
                    acc   <= acc & c_and;
                    chunk <= done ? '0 : chunk + 1'b1;
                    if (done) state <= RESP;
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_sched.sv
// tb_and_sched: directed self-checking bench for and_sched (NREQ=4, DWIDTH=128, CHUNK=32).
module tb_and_sched;

    localparam int NREQ = 4, DWIDTH = 128, CHUNK = 32, NW = 8, IW = 2;
`ifdef AND_SCHED_EARLY_EXIT_EN
    localparam int LAT_B3 = 2;
`else
    localparam int LAT_B3 = 5;
`endif

    logic                   clk = 1'b0, rst = 1'b1, resp_ready = 1'b0;
    logic [NREQ-1:0]        req_valid = '0, req_ready;
    logic [NREQ*DWIDTH-1:0] req_data = '0;
    logic [NREQ*NW-1:0]     req_n = '0;
    logic                   resp_valid, resp_value, busy;
    logic [IW-1:0]          resp_id;
    int total = 0, bad = 0;

    and_sched #(.NREQ(NREQ), .DWIDTH(DWIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_n(req_n), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .resp_value(resp_value), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic [DWIDTH-1:0] d, input int n);
        req_valid[i] = 1'b1;
        req_data[i*DWIDTH +: DWIDTH] = d;
        req_n[i*NW +: NW] = NW'(n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called one edge after the accept; lat counts edges since the accept cycle, -1 on timeout.
    task automatic wait_resp(output int lat);
        lat = 1;
        for (int i = 0; i < 40 && !resp_valid; i++) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!resp_valid) lat = -1;
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run_one(input int i, input logic [DWIDTH-1:0] d, input int n,
                           output logic [NREQ-1:0] rdy, output int lat);
        req_valid = '0;
        set_req(i, d, n);
        #1 rdy = req_ready;
        @(posedge clk);
        #1 req_valid = '0;
        wait_resp(lat);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
        total++; if (resp_value !== 1'b0) begin bad++; $display("FAIL reset_resp_value: got %b want 0", resp_value); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] rdy;
        int lat;
        run_one(2, '1, 5, rdy, lat);
        total++; if (rdy !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", rdy); end
        total++; if (lat !== 2) begin bad++; $display("FAIL single_lat: got %0d want 2", lat); end
        total++; if (resp_id !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", resp_id); end
        total++; if (resp_value !== 1'b1) begin bad++; $display("FAIL single_value: got %b want 1", resp_value); end
        ack();
        total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_release: got valid=%b busy=%b want 0 0", resp_valid, busy); end
    endtask

    task automatic test_zero_bit();
        logic [NREQ-1:0] rdy;
        logic [DWIDTH-1:0] d;
        int lat;
        d = '1;
        d[100] = 1'b0;
        run_one(0, d, 128, rdy, lat);
        total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL b100_grant: got %b want 0001", rdy); end
        total++; if (lat !== 5) begin bad++; $display("FAIL b100_lat: got %0d want 5", lat); end
        total++; if (resp_value !== 1'b0 || resp_id !== 2'd0) begin bad++; $display("FAIL b100_resp: got value=%b id=%0d want 0 0", resp_value, resp_id); end
        ack();
        d = '1;
        d[3] = 1'b0;
        run_one(0, d, 128, rdy, lat);
        total++; if (lat !== LAT_B3) begin bad++; $display("FAIL b3_lat: got %0d want %0d", lat, LAT_B3); end
        total++; if (resp_value !== 1'b0) begin bad++; $display("FAIL b3_value: got %b want 0", resp_value); end
        ack();
    endtask

    task automatic test_round_robin();
        int ids[5] = '{0, 1, 2, 3, 0};
        logic vals[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int lat;
        do_reset();
        set_req(0, '1, 32);
        set_req(1, '0, 1);
        set_req(2, '1, 32);
        set_req(3, '1, 32);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== NREQ'(1) << ids[k]) begin bad++; $display("FAIL rr_grant%0d: got %b want %0d", k, req_ready, ids[k]); end
            @(posedge clk);
            #1 if (k == 4) req_valid = '0;
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rr_holdoff%0d: got %b want 0000", k, req_ready); end
            wait_resp(lat);
            total++; if (lat !== 2 || resp_id !== IW'(ids[k]) || resp_value !== vals[k]) begin
                bad++; $display("FAIL rr_resp%0d: got lat=%0d id=%0d value=%b want 2 %0d %b", k, lat, resp_id, resp_value, ids[k], vals[k]);
            end
            ack();
        end
    endtask

    task automatic test_n_zero_clamp();
        logic [NREQ-1:0] rdy;
        logic [DWIDTH-1:0] d;
        int lat;
        run_one(1, '0, 0, rdy, lat);
        total++; if (lat !== 2 || resp_value !== 1'b1 || resp_id !== 2'd1) begin bad++; $display("FAIL n0: got lat=%0d value=%b id=%0d want 2 1 1", lat, resp_value, resp_id); end
        ack();
        run_one(3, '1, 200, rdy, lat);
        total++; if (lat !== 5 || resp_value !== 1'b1 || resp_id !== 2'd3) begin bad++; $display("FAIL clamp_ones: got lat=%0d value=%b id=%0d want 5 1 3", lat, resp_value, resp_id); end
        ack();
        d = '1;
        d[127] = 1'b0;
        run_one(3, d, 200, rdy, lat);
        total++; if (lat !== 5 || resp_value !== 1'b0) begin bad++; $display("FAIL clamp_b127: got lat=%0d value=%b want 5 0", lat, resp_value); end
        ack();
    endtask

    task automatic test_hold();
        logic [DWIDTH-1:0] d;
        int lat;
        d = '1;
        d[40] = 1'b0;
        req_valid = '0;
        set_req(2, d, 64);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL hold_grant: got %b want 0100", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        set_req(0, '1, 1);
        resp_ready = 1'b1;
        wait_resp(lat);
        resp_ready = 1'b0;
        total++; if (lat !== 3) begin bad++; $display("FAIL hold_lat: got %0d want 3", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_value !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL hold_stable%0d: got valid=%b id=%0d value=%b ready=%b busy=%b want 1 2 0 0000 1", i, resp_valid, resp_id, resp_value, req_ready, busy);
            end
        end
        ack();
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL hold_next_grant: got %b want 0001", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        wait_resp(lat);
        total++; if (lat !== 2 || resp_id !== 2'd0 || resp_value !== 1'b1) begin bad++; $display("FAIL hold_next_resp: got lat=%0d id=%0d value=%b want 2 0 1", lat, resp_id, resp_value); end
        ack();
    endtask

    task automatic test_reset_mid();
        int seen = 0, lat;
        req_valid = '0;
        set_req(0, '1, 128);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        total++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_id !== 2'd0 || resp_value !== 1'b0) begin
            bad++; $display("FAIL mid_reset_outs: got valid=%b busy=%b id=%0d value=%b want 0 0 0 0", resp_valid, busy, resp_id, resp_value);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (resp_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_stale_resp: got %0d cycles want 0", seen); end
        set_req(1, '1, 8);
        set_req(0, '1, 8);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_rr_ptr: got %b want 0001", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        wait_resp(lat);
        total++; if (lat !== 2 || resp_id !== 2'd0 || resp_value !== 1'b1) begin bad++; $display("FAIL mid_after_resp: got lat=%0d id=%0d value=%b want 2 0 1", lat, resp_id, resp_value); end
        ack();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_bit();
        test_round_robin();
        test_n_zero_clamp();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
